// File: rtl/sort_ctrl.sv
// sort_ctrl: grants one of two requesters a sort job and sequences it through
// sorter clear, key feed, result forwarding and completion/timeout reporting.
module sort_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4,
  parameter int WAIT_LIMIT       = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req,
  output logic [1:0]                  gnt,
  output logic [1:0]                  jdone,
  output logic                        jerr,
  output logic                        um_rd_en,
  output logic [LOG2_ELEMENT_NUM:0]   um_rd_addr,
  input  logic [DATA_WIDTH-1:0]       um_rd_data,
  output logic                        srt_rst,
  output logic                        UM_valid,
  output logic [DATA_WIDTH-1:0]       UM_data,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        done,
  output logic                        rm_we,
  output logic [LOG2_ELEMENT_NUM:0]   rm_addr,
  output logic [DATA_WIDTH-1:0]       rm_data
);
  localparam int CW = $clog2(WAIT_LIMIT + ELEMENT_NUM + 1);
  typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic owner_q, owner_d, ptr_q, ptr_d, pick, busy, timeout;
  logic [1:0] gnt_q, gnt_d, jdone_q, jdone_d;
  logic jerr_q, jerr_d, srt_rst_q, srt_rst_d, um_rd_en_q, um_rd_en_d, um_valid_q, rm_we_q, rm_we_d;
  logic [LOG2_ELEMENT_NUM:0] um_rd_addr_q, um_rd_addr_d, rm_addr_q, rm_addr_d;
  logic [DATA_WIDTH-1:0] um_data_q, um_data_d, rm_data_q, rm_data_d;
  // ptr_q names the requester that wins a tie; it flips away from each winner
  always_comb begin
    pick = (req == 2'b11) ? ptr_q : req[1];
    busy = (state_q == FEED) || (state_q == WAIT);
    timeout = (state_q == WAIT) && !done && (cnt_q == CW'(WAIT_LIMIT - 1));
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    owner_d = owner_q;
    ptr_d = ptr_q;
    gnt_d = 2'b00;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          state_d = CLR;
          owner_d = pick;
          ptr_d = ~pick;
          gnt_d = pick ? 2'b10 : 2'b01;
        end
      end
      CLR: if (cnt_q == CW'(1)) begin
        state_d = FEED;
        cnt_d = '0;
      end
      FEED: if (done) state_d = FIN;
        else if (cnt_q == CW'(ELEMENT_NUM)) begin
          state_d = WAIT;
          cnt_d = '0;
        end
      WAIT: if (done || timeout) state_d = FIN;
      default: state_d = IDLE;
    endcase
    srt_rst_d = (state_d == CLR);
    um_rd_en_d = (state_d == FEED) && (cnt_d < CW'(ELEMENT_NUM));
    um_rd_addr_d = um_rd_en_d ? {owner_d, cnt_d[LOG2_ELEMENT_NUM-1:0]} : um_rd_addr_q;
    um_data_d = um_rd_en_q ? um_rd_data : um_data_q;
    jdone_d = (state_d == FIN) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    jerr_d = timeout;
    rm_we_d = busy && SM_valid;
    rm_addr_d = rm_we_d ? {owner_q, SM_addr} : rm_addr_q;
    rm_data_d = rm_we_d ? SM_data : rm_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      owner_q <= 1'b0;
      ptr_q <= 1'b0;
      gnt_q <= 2'b00;
      jdone_q <= 2'b00;
      jerr_q <= 1'b0;
      srt_rst_q <= 1'b1;
      um_rd_en_q <= 1'b0;
      um_rd_addr_q <= '0;
      um_valid_q <= 1'b0;
      um_data_q <= '0;
      rm_we_q <= 1'b0;
      rm_addr_q <= '0;
      rm_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      jdone_q <= jdone_d;
      jerr_q <= jerr_d;
      srt_rst_q <= srt_rst_d;
      um_rd_en_q <= um_rd_en_d;
      um_rd_addr_q <= um_rd_addr_d;
      um_valid_q <= um_rd_en_q;
      um_data_q <= um_data_d;
      rm_we_q <= rm_we_d;
      rm_addr_q <= rm_addr_d;
      rm_data_q <= rm_data_d;
    end
  end
  assign gnt = gnt_q;
  assign jdone = jdone_q;
  assign jerr = jerr_q;
  assign srt_rst = srt_rst_q;
  assign um_rd_en = um_rd_en_q;
  assign um_rd_addr = um_rd_addr_q;
  assign UM_valid = um_valid_q;
  assign UM_data = um_data_q;
  assign rm_we = rm_we_q;
  assign rm_addr = rm_addr_q;
  assign rm_data = rm_data_q;
endmodule
